// File: rtl/cp0_exc_ctrl_if.sv
// CP0 access bus between the multicycle control FSM and cp0_exc_ctrl.
//   we/addr/wdata     mtc0 write strobe, register number, write data
//   rdata             mfc0 read data (combinational from addr)
//   irq               external interrupt levels
//   exc_req/exc_code  exception entry pulse and its ExcCode
//   exc_pc            PC saved into EPC on a non-nested entry
//   eret              return-from-exception pulse
//   epc/status        current EPC and Status register values
//   int_pending       an unmasked interrupt is ready to be taken
interface cp0_exc_ctrl_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_IRQ = 5
);
    logic              we;
    logic [4:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [NUM_IRQ-1:0] irq;
    logic              exc_req;
    logic [4:0]        exc_code;
    logic [DATA_W-1:0] exc_pc;
    logic              eret;
    logic [DATA_W-1:0] epc;
    logic [DATA_W-1:0] status;
    logic              int_pending;

    // Control FSM side.
    modport master (
        output we, addr, wdata, irq, exc_req, exc_code, exc_pc, eret,
        input  rdata, epc, status, int_pending
    );

    // CP0 side.
    modport slave (
        input  we, addr, wdata, irq, exc_req, exc_code, exc_pc, eret,
        output rdata, epc, status, int_pending
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// MIPS CP0 subset: Count/Compare timer, Status, Cause and EPC, with
// exception entry / ERET sequencing and interrupt masking.
//   clk        clock
//   rst        asynchronous active-high reset
//   bus        cp0_exc_ctrl_if.slave: mtc0/mfc0 access, irq lines,
//              exc_req/eret from the control FSM, epc/status/int_pending out
module cp0_exc_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_IRQ  = 5,
    parameter int unsigned TIMER_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_ctrl_if.slave bus
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [DATA_W-1:0]  count;
    logic [DATA_W-1:0]  compare;
    logic [DATA_W-1:0]  epc;
    logic               ie;
    logic               exl;
    logic [7:0]         im;
    logic [4:0]         exc_code;
    logic [1:0]         ip_sw;
    logic [NUM_IRQ-1:0] ip_hw;
    logic               ti;

    logic [7:0]         ip;
    logic [DATA_W-1:0]  status_word;
    logic [DATA_W-1:0]  cause_word;

    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    // Only the low 16 bits of wdata map to Status/Cause fields.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    assign wr_count   = bus.we && (bus.addr == REG_COUNT);
    assign wr_compare = bus.we && (bus.addr == REG_COMPARE);
    assign wr_status  = bus.we && (bus.addr == REG_STATUS);
    assign wr_cause   = bus.we && (bus.addr == REG_CAUSE);
    assign wr_epc     = bus.we && (bus.addr == REG_EPC);

    // Count/Compare timer; a Compare write beats a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else if (TIMER_EN != 0) begin
            if (wr_count) begin
                count <= bus.wdata;
            end else begin
                count <= count + DATA_W'(1);
            end
            if (wr_compare) begin
                compare <= bus.wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

    // Status: exception entry owns EXL over both eret and an mtc0 write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie  <= 1'b0;
            exl <= 1'b0;
            im  <= '0;
        end else begin
            if (wr_status) begin
                ie  <= bus.wdata[0];
                exl <= bus.wdata[1];
                im  <= bus.wdata[15:8];
            end
            if (bus.exc_req) begin
                exl <= 1'b1;
            end else if (bus.eret) begin
                exl <= 1'b0;
            end
        end
    end

    // Cause: software IP bits are writable, hardware IP bits follow irq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_code <= '0;
            ip_sw    <= '0;
            ip_hw    <= '0;
        end else begin
            ip_hw <= bus.irq;
            if (wr_cause) begin
                ip_sw <= bus.wdata[9:8];
            end
            if (bus.exc_req) begin
                exc_code <= bus.exc_code;
            end
        end
    end

    // EPC: nested entries (EXL already set) keep the original return PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= '0;
        end else if (bus.exc_req && !exl) begin
            epc <= bus.exc_pc;
        end else if (wr_epc) begin
            epc <= bus.wdata;
        end
    end

    // Architectural views of Status and Cause.
    always_comb begin
        ip                 = '0;
        ip[1:0]            = ip_sw;
        ip[2 +: NUM_IRQ]   = ip_hw;
        ip[7]              = ti;

        status_word        = '0;
        status_word[0]     = ie;
        status_word[1]     = exl;
        status_word[15:8]  = im;

        cause_word         = '0;
        cause_word[6:2]    = exc_code;
        cause_word[15:8]   = ip;
    end

    // mfc0 read mux, pre-edge register state.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            REG_COUNT:   bus.rdata = count;
            REG_COMPARE: bus.rdata = compare;
            REG_STATUS:  bus.rdata = status_word;
            REG_CAUSE:   bus.rdata = cause_word;
            REG_EPC:     bus.rdata = epc;
            default:     bus.rdata = '0;
        endcase
    end

    assign bus.int_pending = ie & ~exl & (|(ip & im));
    assign bus.epc         = epc;
    assign bus.status      = status_word;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: expected values are queued when the
// stimulus is applied and popped when the corresponding output is sampled.
module tb_cp0_exc_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_IRQ = 5;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_NONE    = 5'd3;
    localparam logic [4:0] A_HIGH    = 5'd31;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] got;
    logic [31:0] want;

    always #5 clk = ~clk;

    cp0_exc_ctrl_if #(.DATA_W(DATA_W), .NUM_IRQ(NUM_IRQ)) bus ();

    cp0_exc_ctrl #(.DATA_W(DATA_W), .NUM_IRQ(NUM_IRQ), .TIMER_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cyc();
        bus.we    = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc);
        bus.exc_req  = 1'b1;
        bus.exc_code = code;
        bus.exc_pc   = pc;
        cyc();
        bus.exc_req  = 1'b0;
    endtask

    task automatic eret_pulse();
        bus.eret = 1'b1;
        cyc();
        bus.eret = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        repeat (7) sb.push_back(32'h0);
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_count got=%h want=%h", got, want); end
        rd(A_COMPARE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_compare got=%h want=%h", got, want); end
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_status got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_cause got=%h want=%h", got, want); end
        rd(A_EPC, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_epc got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_int_pending got=%h want=%h", got, want); end
        got = bus.status; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_status_out got=%h want=%h", got, want); end
    endtask

    task automatic test_midrun_reset();
        wr(A_COUNT, 32'h123);
        exc(5'd2, 32'h55);
        sb.push_back(32'h124); sb.push_back(32'h2); sb.push_back(32'h55);
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL mid_count got=%h want=%h", got, want); end
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL mid_status got=%h want=%h", got, want); end
        got = bus.epc; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL mid_epc got=%h want=%h", got, want); end
        rst = 1'b1;
        #1;
        repeat (5) sb.push_back(32'h0);
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst2_count got=%h want=%h", got, want); end
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst2_status got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst2_cause got=%h want=%h", got, want); end
        got = bus.epc; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst2_epc got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst2_int_pending got=%h want=%h", got, want); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timer();
        // Count=0 here; Compare write lands at Count 0->1, Status at 1->2.
        wr(A_COMPARE, 32'd5);
        wr(A_STATUS, 32'h8001);
        sb.push_back(32'h0);
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_pend_early got=%h want=%h", got, want); end
        repeat (3) cyc();
        sb.push_back(32'd5); sb.push_back(32'h0); sb.push_back(32'h0);
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_count5 got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_cause_pre got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_pend_pre got=%h want=%h", got, want); end
        cyc();
        sb.push_back(32'h8000); sb.push_back(32'h1); sb.push_back(32'd6);
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_cause_ti got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_pend_ti got=%h want=%h", got, want); end
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_count6 got=%h want=%h", got, want); end
        wr(A_COMPARE, 32'd20);
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'd20);
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_cause_clr got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_pend_clr got=%h want=%h", got, want); end
        rd(A_COMPARE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL tmr_compare got=%h want=%h", got, want); end
        wr(A_COMPARE, 32'h8000_0000);
        wr(A_STATUS, 32'h0);
    endtask

    task automatic test_exception();
        exc(5'd8, 32'h40);
        sb.push_back(32'h40); sb.push_back(32'h2); sb.push_back(32'h20);
        rd(A_EPC, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL exc_epc got=%h want=%h", got, want); end
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL exc_status got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL exc_cause got=%h want=%h", got, want); end
        exc(5'd4, 32'h80);
        sb.push_back(32'h40); sb.push_back(32'h10);
        got = bus.epc; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL nest_epc got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL nest_cause got=%h want=%h", got, want); end
        eret_pulse();
        sb.push_back(32'h0); sb.push_back(32'h40);
        got = bus.status; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL eret_status got=%h want=%h", got, want); end
        rd(A_EPC, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL eret_epc got=%h want=%h", got, want); end
    endtask

    task automatic test_priority();
        bus.eret = 1'b1;
        exc(5'd0, 32'h100);
        bus.eret = 1'b0;
        sb.push_back(32'h2); sb.push_back(32'h100);
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_eret_status got=%h want=%h", got, want); end
        got = bus.epc; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_eret_epc got=%h want=%h", got, want); end
        eret_pulse();
        bus.exc_req = 1'b1; bus.exc_code = 5'd3; bus.exc_pc = 32'h200;
        wr(A_EPC, 32'h99);
        bus.exc_req = 1'b0;
        sb.push_back(32'h200); sb.push_back(32'h0C);
        rd(A_EPC, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_mtc0_epc got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_cause3 got=%h want=%h", got, want); end
        eret_pulse();
        bus.exc_req = 1'b1; bus.exc_code = 5'd5; bus.exc_pc = 32'h300;
        wr(A_STATUS, 32'h1);
        bus.exc_req = 1'b0;
        sb.push_back(32'h3); sb.push_back(32'h300);
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_mtc0_status got=%h want=%h", got, want); end
        rd(A_EPC, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_status_epc got=%h want=%h", got, want); end
        wr(A_STATUS, 32'h0);
        bus.exc_req = 1'b1; bus.exc_code = 5'd5; bus.exc_pc = 32'h400;
        wr(A_CAUSE, 32'hFFFF_FFFF);
        bus.exc_req = 1'b0;
        sb.push_back(32'h314); sb.push_back(32'h2);
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_mtc0_cause got=%h want=%h", got, want); end
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_cause_status got=%h want=%h", got, want); end
        wr(A_CAUSE, 32'h0);
        sb.push_back(32'h14);
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL pri_cause_sw_clr got=%h want=%h", got, want); end
        eret_pulse();
    endtask

    task automatic test_irq();
        bus.irq = NUM_IRQ'(1);
        wr(A_STATUS, 32'h0403);
        sb.push_back(32'h0403); sb.push_back(32'h0414); sb.push_back(32'h0);
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_status got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_cause got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_pend_exl got=%h want=%h", got, want); end
        wr(A_STATUS, 32'h0401);
        sb.push_back(32'h1);
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_pend_on got=%h want=%h", got, want); end
        bus.irq = '0;
        #1;
        sb.push_back(32'h1);
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_pend_latency got=%h want=%h", got, want); end
        cyc();
        sb.push_back(32'h0); sb.push_back(32'h14);
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_pend_drop got=%h want=%h", got, want); end
        rd(A_CAUSE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL irq_cause_drop got=%h want=%h", got, want); end
        wr(A_STATUS, 32'h0);
    endtask

    task automatic test_wrap_unimpl();
        wr(A_COUNT, 32'hFFFF_FFFF);
        sb.push_back(32'hFFFF_FFFF);
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL wrap_load got=%h want=%h", got, want); end
        cyc();
        sb.push_back(32'h0);
        rd(A_COUNT, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL wrap_zero got=%h want=%h", got, want); end
        wr(A_NONE, 32'hDEAD_BEEF);
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h8000_0000);
        rd(A_NONE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL unimpl_addr3 got=%h want=%h", got, want); end
        rd(A_HIGH, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL unimpl_addr31 got=%h want=%h", got, want); end
        rd(A_COMPARE, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL unimpl_compare got=%h want=%h", got, want); end
        wr(A_STATUS, 32'hFFFF_FFFF);
        sb.push_back(32'h0000_FF03); sb.push_back(32'h0);
        rd(A_STATUS, got); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL status_mask got=%h want=%h", got, want); end
        got = {31'b0, bus.int_pending}; want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL status_mask_pend got=%h want=%h", got, want); end
        wr(A_STATUS, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            sb.push_back(d);
            wr(A_EPC, d);
            rd(A_EPC, got); want = sb.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL b2b_epc[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.we       = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.irq      = '0;
        bus.exc_req  = 1'b0;
        bus.exc_code = '0;
        bus.exc_pc   = '0;
        bus.eret     = 1'b0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_midrun_reset();
        test_timer();
        test_exception();
        test_priority();
        test_irq();
        test_wrap_unimpl();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
